voice_allocator: RTL and testbench

VOICE_ALLOCATOR -- requirements
Module: voice_allocator

---
 rtl/voice_allocator_if.sv | 32 +++
 rtl/voice_allocator.sv | 241 ++++++++++++++++++++++++
 tb/tb_voice_allocator.sv | 425 ++++++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/voice_allocator_if.sv
// Handshake and data bundle between the note/sample side and voice_allocator.
// master: note source and note players; slave: the allocator/mixer.
interface voice_allocator_if #(
    parameter int NUM_VOICES = 4
);
    logic                       load_new_note;
    logic [5:0]                 note_to_load;
    logic [5:0]                 duration_to_load;
    logic [NUM_VOICES-1:0]      voice_playing;
    logic [16*NUM_VOICES-1:0]   voice_sample;
    logic [NUM_VOICES-1:0]      voice_sample_ready;
    logic [NUM_VOICES-1:0]      voice_load;
    logic [5:0]                 voice_note;
    logic [5:0]                 voice_duration;
    logic [15:0]                sample_out;
    logic                       new_sample_ready;
    logic                       dropped_note;

    modport master (
        output load_new_note, note_to_load, duration_to_load,
               voice_playing, voice_sample, voice_sample_ready,
        input  voice_load, voice_note, voice_duration,
               sample_out, new_sample_ready, dropped_note
    );

    modport slave (
        input  load_new_note, note_to_load, duration_to_load,
               voice_playing, voice_sample, voice_sample_ready,
        output voice_load, voice_note, voice_duration,
               sample_out, new_sample_ready, dropped_note
    );
endinterface

// File: rtl/voice_allocator.sv
// Voice allocator and sample mixer.
// Notes go to the lowest-index idle voice; when every voice is busy the note is
// dropped, or, with the VOICE_STEAL_EN macro defined, the oldest voice is stolen.
// Voice samples are attenuated by SHIFT, summed one voice per cycle and saturated.
module voice_allocator #(
    parameter int NUM_VOICES = 4,
    parameter int SHIFT      = 2
) (
    input logic              clk,
    input logic              reset,
    voice_allocator_if.slave bus
);
    localparam int AW   = $clog2(NUM_VOICES);
    localparam int ACCW = 16 + AW;
    localparam int IW   = $clog2(NUM_VOICES + 1);

    typedef enum logic [1:0] {IDLE, ACCUM, OUT} mix_state_e;

    // ---------------- allocator ----------------
    logic [NUM_VOICES-1:0] pend_q;
    logic [1:0]            pcnt_q [NUM_VOICES];
    logic [NUM_VOICES-1:0] busy;
    logic [NUM_VOICES-1:0] first_idle;
    logic [NUM_VOICES-1:0] sel;
    logic                  found;
    logic                  drop;
    logic [NUM_VOICES-1:0] vload_q;
    logic [5:0]            note_q;
    logic [5:0]            dur_q;
    logic                  drop_q;

`ifdef VOICE_STEAL_EN
    localparam logic [AW-1:0] AGE_MAX = AW'(NUM_VOICES - 1);
    logic [AW-1:0]         age_q [NUM_VOICES];
    logic [AW-1:0]         best_age;
    int unsigned           best_idx;
    logic [NUM_VOICES-1:0] victim;
`endif

    // Find the lowest-index voice that is neither playing nor pending
    always_comb begin
        busy       = bus.voice_playing | pend_q;
        first_idle = '0;
        found      = 1'b0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (!busy[i] && !found) begin
                first_idle[i] = 1'b1;
                found         = 1'b1;
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Pick the oldest voice as steal victim; strict compare keeps the lowest index on ties
    always_comb begin
        best_age = age_q[0];
        best_idx = 0;
        for (int unsigned i = 1; i < NUM_VOICES; i++) begin
            if (age_q[i] > best_age) begin
                best_age = age_q[i];
                best_idx = i;
            end
        end
        victim = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (i == best_idx) victim[i] = 1'b1;
        end
    end
`endif

    // Decide what happens to an incoming note: load a voice or drop it
    always_comb begin
        sel  = '0;
        drop = 1'b0;
        if (bus.load_new_note) begin
            if (found) begin
                sel = first_idle;
            end else begin
`ifdef VOICE_STEAL_EN
                sel = victim;
`else
                drop = 1'b1;
`endif
            end
        end
    end

    // Register the load pulse, shared note/duration and drop pulse
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            vload_q <= '0;
            note_q  <= '0;
            dur_q   <= '0;
            drop_q  <= 1'b0;
        end else begin
            vload_q <= sel;
            drop_q  <= drop;
            if (bus.load_new_note) begin
                note_q <= bus.note_to_load;
                dur_q  <= bus.duration_to_load;
            end
        end
    end

    // Pending bits: set with the load, cleared by playing or after three cycles
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_q <= '0;
            for (int unsigned i = 0; i < NUM_VOICES; i++) pcnt_q[i] <= 2'd0;
        end else begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (sel[i]) begin
                    pend_q[i] <= 1'b1;
                    pcnt_q[i] <= 2'd3;
                end else if (pend_q[i]) begin
                    if (bus.voice_playing[i] || pcnt_q[i] == 2'd1) pend_q[i] <= 1'b0;
                    pcnt_q[i] <= pcnt_q[i] - 2'd1;
                end
            end
        end
    end

`ifdef VOICE_STEAL_EN
    // Ages only steer stealing, so they exist only when stealing is built in
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) age_q[i] <= '0;
        end else if (|sel) begin
            for (int unsigned i = 0; i < NUM_VOICES; i++) begin
                if (sel[i])                 age_q[i] <= '0;
                else if (age_q[i] != AGE_MAX) age_q[i] <= age_q[i] + AW'(1);
            end
        end
    end
`endif

    assign bus.voice_load     = vload_q;
    assign bus.voice_note     = note_q;
    assign bus.voice_duration = dur_q;
    assign bus.dropped_note   = drop_q;

    // ---------------- mixer ----------------
    mix_state_e             state_q, state_d;
    logic [IW-1:0]          cnt_q, cnt_d;
    logic signed [ACCW-1:0] acc_q, acc_d;
    logic signed [ACCW-1:0] stage_q, stage_d;
    logic signed [ACCW-1:0] ext;
    logic signed [ACCW-1:0] sum;
    logic [15:0]            cur_sample;
    logic [15:0]            sample_q, sample_d;
    logic                   nsr_q, nsr_d;
    logic                   rerun_q, rerun_d;
    logic                   req;

    function automatic logic [15:0] saturate(input logic signed [ACCW-1:0] v);
        if (!v[ACCW-1] && (|v[ACCW-2:15]))      return 16'h7FFF;
        else if (v[ACCW-1] && !(&v[ACCW-2:15])) return 16'h8000;
        else                                    return v[15:0];
    endfunction

    // Select the voice addressed by the counter, sign-extend it and form the running sum
    always_comb begin
        cur_sample = '0;
        for (int unsigned i = 0; i < NUM_VOICES; i++) begin
            if (cnt_q == IW'(i)) cur_sample = bus.voice_sample[16*i +: 16];
        end
        ext = {{(ACCW-16){cur_sample[15]}}, cur_sample};
        sum = acc_q + stage_q;
    end

    // Mixer next state. The selected sample is registered in stage_q before the
    // adder, so ACCUM spends one extra drain cycle folding in the last voice.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        stage_d  = stage_q;
        rerun_d  = rerun_q;
        sample_d = sample_q;
        nsr_d    = 1'b0;
        req      = |bus.voice_sample_ready;
        case (state_q)
            IDLE: begin
                if (req) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    acc_d   = '0;
                    stage_d = '0;
                end
            end
            ACCUM: begin
                if (req) rerun_d = 1'b1;
                if (cnt_q < IW'(NUM_VOICES)) begin
                    acc_d   = sum;
                    stage_d = ext >>> SHIFT;
                    cnt_d   = cnt_q + IW'(1);
                end else begin
                    sample_d = saturate(sum);
                    nsr_d    = 1'b1;
                    state_d  = OUT;
                end
            end
            OUT: begin
                if (rerun_q || req) begin
                    state_d = ACCUM;
                    cnt_d   = '0;
                    acc_d   = '0;
                    stage_d = '0;
                    rerun_d = 1'b0;
                end else begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Mixer state register; reset abandons any partial sum
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            acc_q    <= '0;
            stage_q  <= '0;
            rerun_q  <= 1'b0;
            sample_q <= '0;
            nsr_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            stage_q  <= stage_d;
            rerun_q  <= rerun_d;
            sample_q <= sample_d;
            nsr_q    <= nsr_d;
        end
    end

    assign bus.sample_out       = sample_q;
    assign bus.new_sample_ready = nsr_q;
endmodule

// File: tb/tb_voice_allocator.sv
// Self-checking bench for voice_allocator (NUM_VOICES=4). Two instances: SHIFT=2
// for allocation and mixing, SHIFT=0 for saturation. Build with VOICE_STEAL_EN
// defined to check the stealing variant.
module tb_voice_allocator;
    localparam int NV = 4;
    localparam int SH = 2;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    voice_allocator_if #(.NUM_VOICES(NV)) vif  ();
    voice_allocator_if #(.NUM_VOICES(NV)) vif0 ();

    voice_allocator #(.NUM_VOICES(NV), .SHIFT(SH)) u_dut (
        .clk   (clk),
        .reset (reset),
        .bus   (vif)
    );

    voice_allocator #(.NUM_VOICES(NV), .SHIFT(0)) u_dut0 (
        .clk   (clk),
        .reset (reset),
        .bus   (vif0)
    );

    // ---------------- reference model (allocation) ----------------
    // A voice is pending from the cycle its load pulse is visible for up to three
    // cycles, unless voice_playing was seen in one of those cycles. Age is the number
    // of loads since the voice was last loaded, capped at NV-1.
    bit m_loaded [NV];
    int m_lc     [NV];
    bit m_clr    [NV];
    int m_since  [NV];
    int cyc;

    task automatic model_reset();
        for (int i = 0; i < NV; i++) begin
            m_loaded[i] = 1'b0;
            m_lc[i]     = 0;
            m_clr[i]    = 1'b0;
            m_since[i]  = 0;
        end
        cyc = 0;
    endtask

    function automatic bit m_pending(input int i, input int c);
        return m_loaded[i] && !m_clr[i] && (c >= m_lc[i]) && (c <= m_lc[i] + 2);
    endfunction

    task automatic model_step(input bit ld, input logic [NV-1:0] play,
                              output logic [NV-1:0] e_load, output bit e_drop);
        int pick;
        int best;
        int age;
        bit pend_now [NV];
        e_load = '0;
        e_drop = 1'b0;
        pick   = -1;
        best   = -1;
        for (int i = 0; i < NV; i++) pend_now[i] = m_pending(i, cyc);
        if (ld) begin
            for (int i = 0; i < NV; i++)
                if (pick < 0 && !play[i] && !pend_now[i]) pick = i;
            if (pick < 0) begin
`ifdef VOICE_STEAL_EN
                for (int i = 0; i < NV; i++) begin
                    age = (m_since[i] > NV - 1) ? NV - 1 : m_since[i];
                    if (age > best) begin
                        best = age;
                        pick = i;
                    end
                end
`else
                e_drop = 1'b1;
`endif
            end
        end
        for (int i = 0; i < NV; i++)
            if (play[i] && pend_now[i]) m_clr[i] = 1'b1;
        if (pick >= 0) begin
            e_load[pick] = 1'b1;
            for (int i = 0; i < NV; i++) m_since[i]++;
            m_since[pick]  = 0;
            m_loaded[pick] = 1'b1;
            m_lc[pick]     = cyc + 1;
            m_clr[pick]    = 1'b0;
        end
        cyc++;
    endtask

    // ---------------- reference model (mix) ----------------
    function automatic logic [15:0] mix_model(input logic [16*NV-1:0] s, input int sh);
        int total;
        logic signed [15:0] v;
        total = 0;
        for (int i = 0; i < NV; i++) begin
            v = s[16*i +: 16];
            total += (int'(v) >>> sh);
        end
        if (total > 32767)  total = 32767;
        if (total < -32768) total = -32768;
        return total[15:0];
    endfunction

    // ---------------- helpers ----------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive_idle();
        vif.load_new_note       = 1'b0;
        vif.note_to_load        = '0;
        vif.duration_to_load    = '0;
        vif.voice_playing       = '0;
        vif.voice_sample_ready  = '0;
        vif0.load_new_note      = 1'b0;
        vif0.note_to_load       = '0;
        vif0.duration_to_load   = '0;
        vif0.voice_playing      = '0;
        vif0.voice_sample_ready = '0;
    endtask

    task automatic do_reset();
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        reset = 1'b0;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        vif.voice_sample  = '0;
        vif0.voice_sample = '0;
        drive_idle();
        reset = 1'b1;
        tick();
        tick();
        n_checks++;
        if (vif.voice_load !== 4'b0000) begin
            n_fail++; $display("FAIL reset_voice_load: got %b expected 0000", vif.voice_load);
        end
        n_checks++;
        if ({vif.voice_note, vif.voice_duration} !== 12'h000) begin
            n_fail++; $display("FAIL reset_note_dur: got %h expected 000", {vif.voice_note, vif.voice_duration});
        end
        n_checks++;
        if ({vif.sample_out, vif.new_sample_ready, vif.dropped_note} !== 18'h0) begin
            n_fail++; $display("FAIL reset_mix_outputs: got %h expected 0", {vif.sample_out, vif.new_sample_ready, vif.dropped_note});
        end
        n_checks++;
        if ({vif0.voice_load, vif0.sample_out, vif0.new_sample_ready, vif0.dropped_note} !== 22'h0) begin
            n_fail++; $display("FAIL reset_inst0: got %h expected 0", {vif0.voice_load, vif0.sample_out, vif0.new_sample_ready, vif0.dropped_note});
        end
        reset = 1'b0;
    endtask

    task automatic test_first_load();
        do_reset();
        vif.load_new_note    = 1'b1;
        vif.note_to_load     = 6'd20;
        vif.duration_to_load = 6'd8;
        tick();
        vif.load_new_note = 1'b0;
        n_checks++;
        if (vif.voice_load !== 4'b0001) begin
            n_fail++; $display("FAIL first_load: got %b expected 0001", vif.voice_load);
        end
        n_checks++;
        if (vif.voice_note !== 6'd20 || vif.voice_duration !== 6'd8) begin
            n_fail++; $display("FAIL first_note_dur: got %0d/%0d expected 20/8", vif.voice_note, vif.voice_duration);
        end
        tick();
        n_checks++;
        if (vif.voice_load !== 4'b0000) begin
            n_fail++; $display("FAIL load_one_cycle: got %b expected 0000", vif.voice_load);
        end
    endtask

    task automatic test_back_to_back();
        logic [NV-1:0] exp_seq [4];
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
        do_reset();
        for (int k = 0; k < 3; k++) begin
            vif.load_new_note = 1'b1;
            vif.note_to_load  = 6'(k + 1);
            tick();
            n_checks++;
            if (vif.voice_load !== exp_seq[k] || vif.voice_note !== 6'(k + 1)) begin
                n_fail++; $display("FAIL back_to_back_%0d: got %b/%0d expected %b/%0d", k, vif.voice_load, vif.voice_note, exp_seq[k], k + 1);
            end
        end
        vif.load_new_note = 1'b0;
        tick();
    endtask

    task automatic test_all_busy();
        logic [NV-1:0] exp_seq [4];
        logic [NV-1:0] exp_load;
        logic          exp_drop;
        exp_seq = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};
`ifdef VOICE_STEAL_EN
        exp_load = 4'b0001;
        exp_drop = 1'b0;
`else
        exp_load = 4'b0000;
        exp_drop = 1'b1;
`endif
        do_reset();
        for (int k = 0; k < 4; k++) begin
            vif.load_new_note = 1'b1;
            tick();
            n_checks++;
            if (vif.voice_load !== exp_seq[k]) begin
                n_fail++; $display("FAIL fill_voice_%0d: got %b expected %b", k, vif.voice_load, exp_seq[k]);
            end
        end
        vif.voice_playing = 4'b1111;
        tick();
        vif.load_new_note = 1'b0;
        n_checks++;
        if (vif.voice_load !== exp_load || vif.dropped_note !== exp_drop) begin
            n_fail++; $display("FAIL fifth_note: got load=%b drop=%b expected load=%b drop=%b", vif.voice_load, vif.dropped_note, exp_load, exp_drop);
        end
        tick();
        n_checks++;
        if (vif.dropped_note !== 1'b0 || vif.voice_load !== 4'b0000) begin
            n_fail++; $display("FAIL fifth_note_pulse_end: got load=%b drop=%b expected 0000/0", vif.voice_load, vif.dropped_note);
        end
        vif.voice_playing = '0;
    endtask

    task automatic test_random_alloc();
        logic [NV-1:0] e_load;
        bit            e_drop;
        logic [NV-1:0] play;
        bit            ld;
        logic [5:0]    nt, du;
        int            bad;
        do_reset();
        model_reset();
        bad = 0;
        for (int k = 0; k < 300; k++) begin
            ld = ($urandom_range(0, 9) < 6);
            for (int i = 0; i < NV; i++) play[i] = ($urandom_range(0, 9) < 6);
            nt = 6'($urandom);
            du = 6'($urandom);
            vif.load_new_note    = ld;
            vif.note_to_load     = nt;
            vif.duration_to_load = du;
            vif.voice_playing    = play;
            model_step(ld, play, e_load, e_drop);
            tick();
            n_checks++;
            if (vif.voice_load !== e_load || vif.dropped_note !== e_drop) begin
                n_fail++;
                if (bad < 10) $display("FAIL rand_alloc_%0d: got load=%b drop=%b expected load=%b drop=%b", k, vif.voice_load, vif.dropped_note, e_load, e_drop);
                bad++;
            end
            if (e_load != '0) begin
                n_checks++;
                if (vif.voice_note !== nt || vif.voice_duration !== du) begin
                    n_fail++;
                    if (bad < 10) $display("FAIL rand_note_%0d: got %0d/%0d expected %0d/%0d", k, vif.voice_note, vif.voice_duration, nt, du);
                    bad++;
                end
            end
        end
        drive_idle();
        tick();
    endtask

    task automatic test_mix_saturate();
        int lat;
        do_reset();
        vif0.voice_sample       = {4{16'h7000}};
        vif0.voice_sample_ready = 4'b0001;
        tick();
        vif0.voice_sample_ready = '0;
        lat = 1;
        while (vif0.new_sample_ready !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== NV + 2) begin
            n_fail++; $display("FAIL sat_latency: got %0d expected %0d", lat, NV + 2);
        end
        n_checks++;
        if (vif0.sample_out !== 16'h7FFF) begin
            n_fail++; $display("FAIL sat_value: got %h expected 7fff", vif0.sample_out);
        end
        tick();
        n_checks++;
        if (vif0.new_sample_ready !== 1'b0) begin
            n_fail++; $display("FAIL sat_pulse_width: got %b expected 0", vif0.new_sample_ready);
        end
    endtask

    task automatic test_mix_rerun();
        int pulses [$];
        logic [15:0] vals [$];
        do_reset();
        vif.voice_sample       = {16'h0000, 16'h0800, 16'hFC00, 16'h0400};
        vif.voice_sample_ready = 4'b0001;
        for (int k = 1; k <= 16; k++) begin
            tick();
            vif.voice_sample_ready = (k == 2) ? 4'b0100 : 4'b0000;
            if (vif.new_sample_ready === 1'b1) begin
                pulses.push_back(k);
                vals.push_back(vif.sample_out);
            end
        end
        n_checks++;
        if (pulses.size() !== 2) begin
            n_fail++; $display("FAIL rerun_pulse_count: got %0d expected 2", pulses.size());
        end else begin
            n_checks++;
            if (pulses[0] !== 6 || pulses[1] !== 12) begin
                n_fail++; $display("FAIL rerun_timing: got %0d,%0d expected 6,12", pulses[0], pulses[1]);
            end
            n_checks++;
            if (vals[0] !== 16'h0200 || vals[1] !== 16'h0200) begin
                n_fail++; $display("FAIL rerun_value: got %h,%h expected 0200,0200", vals[0], vals[1]);
            end
        end
    endtask

    task automatic test_mix_random();
        logic [16*NV-1:0] s;
        logic [NV-1:0]    rdy;
        int lat;
        do_reset();
        for (int it = 0; it < 10; it++) begin
            for (int i = 0; i < NV; i++) s[16*i +: 16] = 16'($urandom);
            if (it < 3) for (int i = 0; i < NV; i++) s[16*i + 15 -: 2] = (it == 1) ? 2'b10 : 2'b01;
            rdy = 4'($urandom_range(1, 15));
            vif.voice_sample        = s;
            vif0.voice_sample       = s;
            vif.voice_sample_ready  = rdy;
            vif0.voice_sample_ready = rdy;
            tick();
            vif.voice_sample_ready  = '0;
            vif0.voice_sample_ready = '0;
            lat = 1;
            while (vif.new_sample_ready !== 1'b1 && lat < 20) begin
                tick();
                lat++;
            end
            n_checks++;
            if (lat !== NV + 2 || vif0.new_sample_ready !== 1'b1) begin
                n_fail++; $display("FAIL rand_mix_latency_%0d: got %0d/%b expected %0d/1", it, lat, vif0.new_sample_ready, NV + 2);
            end
            n_checks++;
            if (vif.sample_out !== mix_model(s, SH)) begin
                n_fail++; $display("FAIL rand_mix_shift2_%0d: got %h expected %h", it, vif.sample_out, mix_model(s, SH));
            end
            n_checks++;
            if (vif0.sample_out !== mix_model(s, 0)) begin
                n_fail++; $display("FAIL rand_mix_shift0_%0d: got %h expected %h", it, vif0.sample_out, mix_model(s, 0));
            end
            tick();
            tick();
        end
    endtask

    task automatic test_reset_mid_accum();
        int seen;
        int lat;
        vif.voice_sample       = {16'h0100, 16'h0200, 16'h0300, 16'h0400};
        vif.voice_sample_ready = 4'b0010;
        tick();
        vif.voice_sample_ready = '0;
        tick();
        tick();
        reset = 1'b1;
        #1;
        n_checks++;
        if (vif.sample_out !== 16'h0000 || vif.new_sample_ready !== 1'b0) begin
            n_fail++; $display("FAIL midaccum_async_clear: got %h/%b expected 0000/0", vif.sample_out, vif.new_sample_ready);
        end
        tick();
        reset = 1'b0;
        seen = 0;
        for (int k = 0; k < 12; k++) begin
            tick();
            if (vif.new_sample_ready === 1'b1) seen++;
        end
        n_checks++;
        if (seen !== 0) begin
            n_fail++; $display("FAIL midaccum_no_pulse: got %0d pulses expected 0", seen);
        end
        vif.voice_sample_ready = 4'b0001;
        tick();
        vif.voice_sample_ready = '0;
        lat = 1;
        while (vif.new_sample_ready !== 1'b1 && lat < 20) begin
            tick();
            lat++;
        end
        n_checks++;
        if (lat !== NV + 2 || vif.sample_out !== 16'h0280) begin
            n_fail++; $display("FAIL midaccum_recover: got lat=%0d val=%h expected lat=%0d val=0280", lat, vif.sample_out, NV + 2);
        end
    endtask

    initial begin
        test_reset();
        test_first_load();
        test_back_to_back();
        test_all_busy();
        test_random_alloc();
        test_mix_saturate();
        test_mix_rerun();
        test_mix_random();
        test_reset_mid_accum();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
